// File: rtl/pkt_tx_drr_sched.sv
// Deficit-round-robin packet scheduler in front of the shared transmit path.
// Grants one channel at a time a whole packet, holds the one-hot grant until
// the transmit path reports completion, then charges that channel's deficit.
//
// Ports:
//   clk          single clock
//   rst          asynchronous active-low reset
//   req          per-channel "complete packet buffered"
//   head_len     per-channel head packet length (16-bit words), i*LEN_W packed
//   cfg_quantum  per-channel quantum (16-bit words), i*QNT_W packed
//   ack          pulse: transmit path accepted the grant
//   done         pulse: last word of the granted packet sent
//   grant        registered one-hot grant, zero when idle
//   grant_len    latched length of the granted packet
//   busy         high whenever the scheduler is not idle
module pkt_tx_drr_sched #(
  parameter int unsigned CHAN_NUMS = 8,
  parameter int unsigned LEN_W     = 10,
  parameter int unsigned QNT_W     = 11,
  parameter int unsigned DEF_W     = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHAN_NUMS-1:0]       req,
  input  logic [CHAN_NUMS*LEN_W-1:0] head_len,
  input  logic [CHAN_NUMS*QNT_W-1:0] cfg_quantum,
  input  logic                       ack,
  input  logic                       done,
  output logic [CHAN_NUMS-1:0]       grant,
  output logic [LEN_W-1:0]           grant_len,
  output logic                       busy
);

  localparam int unsigned PTR_W = (CHAN_NUMS > 1) ? $clog2(CHAN_NUMS) : 1;
  localparam int unsigned SUM_W = DEF_W + 1;
  localparam logic [DEF_W-1:0] DEF_MAX = '1;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_VISIT = 5'b00010,
    S_CHECK = 5'b00100,
    S_GRANT = 5'b01000,
    S_XFER  = 5'b10000
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [DEF_W-1:0]   deficit [CHAN_NUMS];
  logic               def_we;
  logic [DEF_W-1:0]   def_wdata;
  logic [CHAN_NUMS-1:0] grant_nxt;
  logic [LEN_W-1:0]   grant_len_nxt;

  logic [LEN_W-1:0]   len_arr [CHAN_NUMS];
  logic [QNT_W-1:0]   qnt_arr [CHAN_NUMS];

  logic               req_cur;
  logic               any_req;
  logic [LEN_W-1:0]   len_eff;
  logic [DEF_W-1:0]   def_cur;
  logic [SUM_W-1:0]   def_sum;
  logic [DEF_W-1:0]   def_sat;
  logic               fits;

  // Unpack the per-channel buses
  for (genvar i = 0; i < CHAN_NUMS; i++) begin : g_unpack
    assign len_arr[i] = head_len[i*LEN_W +: LEN_W];
    assign qnt_arr[i] = cfg_quantum[i*QNT_W +: QNT_W];
  end

  // Datapath for the channel under the scan pointer
  always_comb begin
    req_cur = req[ptr];
    any_req = |req;
    def_cur = deficit[ptr];
    // A zero length is illegal; serve it as a one-word packet
    len_eff = (len_arr[ptr] == '0) ? LEN_W'(1) : len_arr[ptr];
    // One spare bit catches the carry so the add can saturate
    def_sum = SUM_W'(def_cur) + SUM_W'(qnt_arr[ptr]);
    def_sat = def_sum[DEF_W] ? DEF_MAX : def_sum[DEF_W-1:0];
    fits    = (def_cur >= DEF_W'(len_eff));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      grant     <= '0;
      grant_len <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      grant_len <= grant_len_nxt;
      busy      <= (state_nxt != S_IDLE);
    end
  end

  // Next-state, pointer, deficit update and grant decisions
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    def_we        = 1'b0;
    def_wdata     = def_cur;
    grant_nxt     = grant;
    grant_len_nxt = grant_len;
    unique case (state)
      S_IDLE: begin
        if (any_req) state_nxt = S_VISIT;
      end
      S_VISIT: begin
        if (req_cur) begin
          def_we    = 1'b1;
          def_wdata = def_sat;
          state_nxt = S_CHECK;
        end else begin
          // An empty channel forfeits any credit it had saved
          def_we    = 1'b1;
          def_wdata = '0;
          ptr_nxt   = ptr + PTR_W'(1);
          state_nxt = any_req ? S_VISIT : S_IDLE;
        end
      end
      S_CHECK: begin
        if (req_cur && fits) begin
          grant_nxt     = CHAN_NUMS'(1) << ptr;
          grant_len_nxt = len_eff;
          state_nxt     = S_GRANT;
        end else begin
          if (!req_cur) begin
            def_we    = 1'b1;
            def_wdata = '0;
          end
          ptr_nxt   = ptr + PTR_W'(1);
          state_nxt = any_req ? S_VISIT : S_IDLE;
        end
      end
      S_GRANT: begin
        if (ack) state_nxt = S_XFER;
      end
      S_XFER: begin
        // CHECK only granted when deficit >= grant_len, so no underflow
        if (done) begin
          def_we    = 1'b1;
          def_wdata = def_cur - DEF_W'(grant_len);
          grant_nxt = '0;
          state_nxt = S_CHECK;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Per-channel deficit counters, written only for the pointed channel
  for (genvar i = 0; i < CHAN_NUMS; i++) begin : g_def
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        deficit[i] <= '0;
      end else if (def_we && (ptr == PTR_W'(i))) begin
        deficit[i] <= def_wdata;
      end
    end
  end

endmodule
